// File: rtl/fetch_decode_pipe_reg_if.sv
// IF->ID pipeline register bus: fetch-side valid/ready with payload, and
// decode-side valid/ready with payload. The master view is the stage pair
// around the register; the slave view is the register itself.
interface fetch_decode_pipe_reg_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ILEN = 32,
  parameter int unsigned SB_W = 1
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [ILEN-1:0] in_inst;
  logic [SB_W-1:0] in_sb;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_inst;
  logic [SB_W-1:0] out_sb;

  modport master (
    output in_valid, in_pc, in_inst, in_sb, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_sb
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_sb, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_sb
  );
endinterface

// File: rtl/fetch_decode_pipe_reg.sv
// IF->ID pipeline register with valid/ready handshake, flush and an optional
// skid entry. With SKID_EN=1 in_ready is a plain flop output, so there is no
// combinational path from decode's out_ready back to fetch. With SKID_EN=0
// the register is a single entry whose in_ready looks through out_ready.
// State encoding is {main_valid, skid_valid}.
module fetch_decode_pipe_reg #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     SB_W     = 1,
  parameter logic [ILEN-1:0] NOP_INST = ILEN'(32'h00000013),
  parameter bit              SKID_EN  = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  fetch_decode_pipe_reg_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_e;

  state_e          state_r;
  state_e          state_nxt_s;

  logic [XLEN-1:0] out_pc_r;
  logic [ILEN-1:0] out_inst_r;
  logic [SB_W-1:0] out_sb_r;

  logic [XLEN-1:0] skid_pc_r;
  logic [ILEN-1:0] skid_inst_r;
  logic [SB_W-1:0] skid_sb_r;

  logic            in_ready_s;
  logic            out_valid_s;
  logic            accept_s;
  logic            drain_s;
  logic            main_from_in_s;
  logic            main_from_skid_s;
  logic            main_clear_s;
  logic            skid_from_in_s;

  assign out_valid_s = state_r[1];

  // Ready toward fetch: skid mode only looks at the skid flop, bypass mode looks through out_ready.
  always_comb begin
    in_ready_s = 1'b0;
    if (SKID_EN) begin
      in_ready_s = ~state_r[0];
    end else begin
      in_ready_s = ~state_r[1] | bus.out_ready;
    end
  end

  assign accept_s = bus.in_valid & in_ready_s;
  assign drain_s  = out_valid_s & bus.out_ready;

  // Next-state and entry-move decode; flush overrides every handshake outcome.
  always_comb begin
    state_nxt_s      = state_r;
    main_from_in_s   = 1'b0;
    main_from_skid_s = 1'b0;
    main_clear_s     = 1'b0;
    skid_from_in_s   = 1'b0;
    if (flush) begin
      state_nxt_s  = ST_EMPTY;
      main_clear_s = 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nxt_s    = ST_ONE;
            main_from_in_s = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (drain_s && accept_s) begin
            state_nxt_s    = ST_ONE;
            main_from_in_s = 1'b1;
          end else if (drain_s) begin
            state_nxt_s  = ST_EMPTY;
            main_clear_s = 1'b1;
          end else if (accept_s) begin
            state_nxt_s    = ST_FULL;
            skid_from_in_s = 1'b1;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (drain_s) begin
            state_nxt_s      = ST_ONE;
            main_from_skid_s = 1'b1;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: begin
          state_nxt_s  = ST_EMPTY;
          main_clear_s = 1'b1;
        end
      endcase
    end
  end

  // State register; reset drops every entry immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Main entry payload; an emptied entry shows the bubble instruction and keeps its PC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_pc_r   <= '0;
      out_inst_r <= NOP_INST;
      out_sb_r   <= '0;
    end else if (main_from_in_s) begin
      out_pc_r   <= bus.in_pc;
      out_inst_r <= bus.in_inst;
      out_sb_r   <= bus.in_sb;
    end else if (main_from_skid_s) begin
      out_pc_r   <= skid_pc_r;
      out_inst_r <= skid_inst_r;
      out_sb_r   <= skid_sb_r;
    end else if (main_clear_s) begin
      out_inst_r <= NOP_INST;
      out_sb_r   <= '0;
    end else begin
      out_pc_r   <= out_pc_r;
      out_inst_r <= out_inst_r;
      out_sb_r   <= out_sb_r;
    end
  end

  // Skid entry payload; its validity lives in state_r[0], so data is only captured.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      skid_pc_r   <= '0;
      skid_inst_r <= NOP_INST;
      skid_sb_r   <= '0;
    end else if (skid_from_in_s) begin
      skid_pc_r   <= bus.in_pc;
      skid_inst_r <= bus.in_inst;
      skid_sb_r   <= bus.in_sb;
    end else begin
      skid_pc_r   <= skid_pc_r;
      skid_inst_r <= skid_inst_r;
      skid_sb_r   <= skid_sb_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_pc    = out_pc_r;
  assign bus.out_inst  = out_inst_r;
  assign bus.out_sb    = out_sb_r;

endmodule

// File: tb/tb_fetch_decode_pipe_reg.sv
// Directed bench for fetch_decode_pipe_reg: a skid build and a single-entry
// build side by side, driven by one linear sequence of steps.
module tb_fetch_decode_pipe_reg;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clock;
  logic reset;
  logic flush;
  int   checks;
  int   errors;

  fetch_decode_pipe_reg_if #(.XLEN(32), .ILEN(32), .SB_W(1)) bus1 ();
  fetch_decode_pipe_reg_if #(.XLEN(32), .ILEN(32), .SB_W(1)) bus2 ();

  fetch_decode_pipe_reg #(
    .XLEN(32), .ILEN(32), .SB_W(1), .NOP_INST(32'h00000013), .SKID_EN(1'b1)
  ) dut_skid (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus1)
  );

  fetch_decode_pipe_reg #(
    .XLEN(32), .ILEN(32), .SB_W(1), .NOP_INST(32'h00000013), .SKID_EN(1'b0)
  ) dut_single (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push1(input logic v, input logic [31:0] pc, input logic [31:0] inst, input logic sb);
    bus1.in_valid = v;
    bus1.in_pc    = pc;
    bus1.in_inst  = inst;
    bus1.in_sb    = sb;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    flush  = 1'b0;
    push1(1'b0, 32'h0, 32'h0, 1'b0);
    bus1.out_ready = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.in_pc     = 32'h0;
    bus2.in_inst   = 32'h0;
    bus2.in_sb     = 1'b0;
    bus2.out_ready = 1'b0;
    #12;

    // Reset state
    chk("rst_out_valid", 32'(bus1.out_valid), 32'h0);
    chk("rst_out_pc",    bus1.out_pc,         32'h0);
    chk("rst_out_inst",  bus1.out_inst,       NOP);
    chk("rst_out_sb",    32'(bus1.out_sb),    32'h0);
    chk("rst_in_ready",  32'(bus1.in_ready),  32'h1);
    reset = 1'b0;

    // 1: single transfer, one-cycle latency
    push1(1'b1, 32'h100, 32'h00500093, 1'b1);
    bus1.out_ready = 1'b1;
    tick();
    chk("t1_out_valid", 32'(bus1.out_valid), 32'h1);
    chk("t1_out_pc",    bus1.out_pc,         32'h100);
    chk("t1_out_inst",  bus1.out_inst,       32'h00500093);
    chk("t1_out_sb",    32'(bus1.out_sb),    32'h1);
    push1(1'b0, 32'hdead, 32'hbeef, 1'b1);
    tick();
    chk("t1_drain_valid", 32'(bus1.out_valid), 32'h0);
    chk("t1_drain_inst",  bus1.out_inst,       NOP);
    chk("t1_drain_sb",    32'(bus1.out_sb),    32'h0);
    chk("t1_drain_pc",    bus1.out_pc,         32'h100);

    // 2: stall fills main then skid
    bus1.out_ready = 1'b0;
    push1(1'b1, 32'h100, 32'h11111111, 1'b0);
    tick();
    chk("t2_ready_one", 32'(bus1.in_ready), 32'h1);
    push1(1'b1, 32'h104, 32'h22222222, 1'b1);
    tick();
    chk("t2_ready_full", 32'(bus1.in_ready), 32'h0);
    chk("t2_pc_held",    bus1.out_pc,        32'h100);
    push1(1'b1, 32'h1ff, 32'h33333333, 1'b0);
    tick();
    chk("t2_pc_still", bus1.out_pc,        32'h100);
    chk("t2_valid",    32'(bus1.out_valid), 32'h1);
    push1(1'b0, 32'h0, 32'h0, 1'b0);
    bus1.out_ready = 1'b1;
    #1;
    chk("t2_ready_no_comb", 32'(bus1.in_ready), 32'h0);
    chk("t2_first_inst",    bus1.out_inst,      32'h11111111);
    tick();
    chk("t2_second_pc",   bus1.out_pc,        32'h104);
    chk("t2_second_inst", bus1.out_inst,      32'h22222222);
    chk("t2_second_sb",   32'(bus1.out_sb),   32'h1);
    chk("t2_ready_back",  32'(bus1.in_ready), 32'h1);
    tick();
    chk("t2_empty", 32'(bus1.out_valid), 32'h0);
    chk("t2_pc_hold", bus1.out_pc,       32'h104);

    // 3: flush while full, with an instruction offered in the flush cycle
    bus1.out_ready = 1'b0;
    push1(1'b1, 32'h200, 32'h44444444, 1'b1);
    tick();
    push1(1'b1, 32'h204, 32'h55555555, 1'b1);
    tick();
    chk("t3_full", 32'(bus1.in_ready), 32'h0);
    flush = 1'b1;
    push1(1'b1, 32'h108, 32'h66666666, 1'b1);
    tick();
    flush = 1'b0;
    push1(1'b0, 32'h0, 32'h0, 1'b0);
    chk("t3_valid", 32'(bus1.out_valid), 32'h0);
    chk("t3_inst",  bus1.out_inst,       NOP);
    chk("t3_sb",    32'(bus1.out_sb),    32'h0);
    chk("t3_pc",    bus1.out_pc,         32'h200);
    chk("t3_ready", 32'(bus1.in_ready),  32'h1);
    bus1.out_ready = 1'b1;
    tick();
    chk("t3_no_108", 32'(bus1.out_valid), 32'h0);

    // 4: streaming, one per cycle
    for (int i = 0; i < 8; i++) begin
      push1(1'b1, 32'(i * 4), 32'(32'h1000 + i), 1'b0);
      #1;
      chk("t4_in_ready", 32'(bus1.in_ready), 32'h1);
      tick();
      chk("t4_valid", 32'(bus1.out_valid), 32'h1);
      chk("t4_pc",    bus1.out_pc,         32'(i * 4));
      chk("t4_inst",  bus1.out_inst,       32'(32'h1000 + i));
    end
    push1(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("t4_end_valid", 32'(bus1.out_valid), 32'h0);
    chk("t4_end_pc",    bus1.out_pc,         32'h1c);

    // 5: async reset between edges
    push1(1'b1, 32'h300, 32'h77777777, 1'b1);
    tick();
    chk("t5_pre_valid", 32'(bus1.out_valid), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(bus1.out_valid), 32'h0);
    chk("t5_rst_inst",  bus1.out_inst,       NOP);
    chk("t5_rst_pc",    bus1.out_pc,         32'h0);
    push1(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    reset = 1'b0;
    tick();
    chk("t5_post_valid", 32'(bus1.out_valid), 32'h0);

    // 6: single-entry build, combinational ready
    bus2.out_ready = 1'b0;
    bus2.in_valid  = 1'b1;
    bus2.in_pc     = 32'h400;
    bus2.in_inst   = 32'h88888888;
    #1;
    chk("t6_ready_empty", 32'(bus2.in_ready), 32'h1);
    tick();
    chk("t6_valid",      32'(bus2.out_valid), 32'h1);
    chk("t6_pc",         bus2.out_pc,         32'h400);
    chk("t6_ready_stall", 32'(bus2.in_ready), 32'h0);
    bus2.in_pc     = 32'h404;
    bus2.in_inst   = 32'h99999999;
    tick();
    chk("t6_pc_held", bus2.out_pc, 32'h400);
    bus2.out_ready = 1'b1;
    #1;
    chk("t6_ready_comb", 32'(bus2.in_ready), 32'h1);
    tick();
    chk("t6_pc_next", bus2.out_pc,   32'h404);
    chk("t6_inst_next", bus2.out_inst, 32'h99999999);
    bus2.in_valid = 1'b0;
    tick();
    chk("t6_empty", 32'(bus2.out_valid), 32'h0);
    chk("t6_nop",   bus2.out_inst,       NOP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
